// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding and hazard unit for the in-order 5-stage pipeline.
// Tracks destination tags of the instructions downstream of ID (tag[1] = EX),
// picks bypass sources for both EX operands and for MEM store data, and raises
// load-use and multi-cycle-multiply stalls.
//
// Ports
//   clk, rst                 pipeline clock, async active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs/id_rt/id_rd        source/destination register indices
//   id_use_rs/id_use_rt      operand consumed by the ALU in EX
//   id_store                 store; rt is read as store data in MEM
//   id_wr                    instruction writes id_rd
//   id_load/id_mul           instruction class
//   flush                    kill the ID instruction
//   fwd_a/fwd_b              registered EX operand selects (0 = regfile, k = source k)
//   fwd_c                    registered MEM store-data select (same encoding)
//   stall_id                 hold PC and IF/ID (combinational)
//   ex_hold                  freeze ID/EX and EX while a multiply runs
//   mul_busy                 multiply counter nonzero
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int SELW     = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_store,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_mul,
  input  logic              flush,
  output logic [SELW-1:0]   fwd_a,
  output logic [SELW-1:0]   fwd_b,
  output logic [SELW-1:0]   fwd_c,
  output logic              stall_id,
  output logic              ex_hold,
  output logic              mul_busy
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              ld;
  } tag_t;

  typedef struct packed {
    logic            hit;
    logic [SELW-1:0] k;
    logic            ld;
  } match_t;

  tag_t [DEPTH:1] tag;
  logic [3:0]     cnt;

  // Youngest producer wins: scan oldest to youngest so the lowest k lands last.
  function automatic match_t lookup(input logic [REG_AW-1:0] r, input tag_t [DEPTH:1] t);
    match_t m;
    m = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (t[k].v && t[k].rd == r && r != '0) begin
        m.hit = 1'b1;
        m.k   = SELW'(k);
        m.ld  = t[k].ld;
      end
    end
    return m;
  endfunction

  match_t          ma, mb;
  logic [SELW-1:0] sel_a, sel_b, sel_c;
  logic            lu_a, lu_b, lu_c, lu, st_only, issue;

  always_comb begin
    ma      = lookup(id_rs, tag);
    mb      = lookup(id_rt, tag);
    st_only = id_store & ~id_use_rt;
    sel_a   = (id_use_rs & ma.hit) ? ma.k : '0;
    sel_b   = (id_use_rt & mb.hit) ? mb.k : '0;
    lu_a    = id_use_rs & ma.hit & ma.ld & (int'(ma.k) <= LOAD_LAT);
    lu_b    = id_use_rt & mb.hit & mb.ld & (int'(mb.k) <= LOAD_LAT);
    // Store data is consumed one stage later, so the producer is one stage
    // further along by then; past the last tracked source it is in the regfile.
    sel_c   = '0;
    if (st_only && mb.hit && (int'(mb.k) + 1 <= DEPTH))
      sel_c = SELW'(int'(mb.k) + 1);
    lu_c    = st_only & mb.hit & mb.ld & (int'(mb.k) + 1 <= LOAD_LAT);
    lu      = id_valid & (lu_a | lu_b | lu_c);
  end

  assign mul_busy = (cnt != 4'd0);
  assign ex_hold  = mul_busy;
  // A flushed instruction must not hold IF/ID, otherwise it would sit in ID
  // and stall again on the following cycle.
  assign stall_id = mul_busy | (lu & ~flush);
  assign issue    = id_valid & ~flush & ~stall_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      cnt   <= 4'd0;
      fwd_a <= '0;
      fwd_b <= '0;
      fwd_c <= '0;
    end else begin
      if (cnt != 4'd0)
        cnt <= cnt - 4'd1;
      else if (issue && id_mul && (MUL_LAT > 1))
        cnt <= 4'(MUL_LAT - 1);

      if (!ex_hold) begin
        for (int k = DEPTH; k >= 2; k--) tag[k] <= tag[k-1];
        tag[1] <= '{v: issue & id_wr, rd: id_rd, ld: id_load};
        fwd_a  <= issue ? sel_a : '0;
        fwd_b  <= issue ? sel_b : '0;
        fwd_c  <= issue ? sel_c : '0;
      end else begin
        // Multiply parked in EX: it stays in tag[1], MEM gets a bubble,
        // everything older keeps draining.
        for (int k = DEPTH; k >= 3; k--) tag[k] <= tag[k-1];
        tag[2] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  localparam int REG_AW = 5, DEPTH = 3, LOAD_LAT = 1, MUL_LAT = 4, SELW = 2;

  // {valid, use_rs, use_rt, store, wr, load, mul}
  localparam logic [6:0] NOP   = 7'b0000000;
  localparam logic [6:0] ALU   = 7'b1110100;
  localparam logic [6:0] ALUI  = 7'b1100100;
  localparam logic [6:0] LW    = 7'b1100110;
  localparam logic [6:0] SW    = 7'b1101000;
  localparam logic [6:0] MUL   = 7'b1110101;
  localparam logic [6:0] NOUSE = 7'b1000000;
  localparam logic [6:0] NOUSW = 7'b1000100;

  logic clk, rst;
  logic id_valid, id_use_rs, id_use_rt, id_store, id_wr, id_load, id_mul, flush;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [SELW-1:0] fwd_a, fwd_b, fwd_c;
  logic stall_id, ex_hold, mul_busy;

  fwd_hazard_unit #(.REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_store(id_store), .id_wr(id_wr),
    .id_load(id_load), .id_mul(id_mul), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .fwd_c(fwd_c), .stall_id(stall_id), .ex_hold(ex_hold), .mul_busy(mul_busy));

  typedef struct {
    string      nm;
    int         a, b, c;
    logic [2:0] shm;   // {stall_id, ex_hold, mul_busy}
  } exp_t;

  exp_t q[$];
  int n_run = 0, n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string f, input int act, input int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "fwd_a",    int'(fwd_a),    e.a);
      chk(e.nm, "fwd_b",    int'(fwd_b),    e.b);
      chk(e.nm, "fwd_c",    int'(fwd_c),    e.c);
      chk(e.nm, "stall_id", int'(stall_id), int'(e.shm[2]));
      chk(e.nm, "ex_hold",  int'(ex_hold),  int'(e.shm[1]));
      chk(e.nm, "mul_busy", int'(mul_busy), int'(e.shm[0]));
    end
  end

  // Drive ID for one cycle and queue what the outputs must show this cycle.
  task automatic cyc(input string nm, input logic [6:0] f, input int rs, input int rt,
                     input int rd, input logic fl, input int ea, input int eb,
                     input int ec, input logic [2:0] shm);
    exp_t e;
    @(posedge clk); #1;
    {id_valid, id_use_rs, id_use_rt, id_store, id_wr, id_load, id_mul} = f;
    id_rs = REG_AW'(rs);
    id_rt = REG_AW'(rt);
    id_rd = REG_AW'(rd);
    flush = fl;
    e.nm = nm; e.a = ea; e.b = eb; e.c = ec; e.shm = shm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1;
    {id_valid, id_use_rs, id_use_rt, id_store, id_wr, id_load, id_mul, flush} = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;

    cyc("reset",      ALU,   1,  2,  3, 0, 0, 0, 0, 3'b000);
    rst = 1'b0;
    // EX-stage forwarding
    cyc("add_r3",     ALU,   1,  2,  3, 0, 0, 0, 0, 3'b000);
    cyc("dep_r3",     ALU,   3,  1,  4, 0, 0, 0, 0, 3'b000);
    cyc("fwd_ex",     NOP,   0,  0,  0, 0, 1, 0, 0, 3'b000);
    // load-use
    cyc("lw_r5",      LW,    2,  0,  5, 0, 0, 0, 0, 3'b000);
    cyc("lu_stall",   ALU,   5,  5,  6, 0, 0, 0, 0, 3'b100);
    cyc("lu_release", ALU,   5,  5,  6, 0, 0, 0, 0, 3'b000);
    cyc("fwd_mem",    NOP,   0,  0,  0, 0, 2, 2, 0, 3'b000);
    // store data after load
    cyc("lw_r5b",     LW,    2,  0,  5, 0, 0, 0, 0, 3'b000);
    cyc("sw_r5",      SW,    2,  5,  0, 0, 0, 0, 0, 3'b000);
    cyc("sw_r5_t2",   SW,    2,  5,  0, 0, 0, 0, 2, 3'b000);
    cyc("fwd_c3",     NOP,   0,  0,  0, 0, 0, 0, 3, 3'b000);
    // youngest producer, r0, unused operands
    cyc("add_r7a",    ALU,   1,  2,  7, 0, 0, 0, 0, 3'b000);
    cyc("add_r7b",    ALUI,  1,  0,  7, 0, 0, 0, 0, 3'b000);
    cyc("use_r7",     ALU,   7,  7,  8, 0, 0, 0, 0, 3'b000);
    cyc("youngest",   NOP,   0,  0,  0, 0, 1, 1, 0, 3'b000);
    cyc("wr_r0",      ALU,   1,  2,  0, 0, 0, 0, 0, 3'b000);
    cyc("use_r0",     ALU,   0,  8,  9, 0, 0, 0, 0, 3'b000);
    cyc("r0_zero",    NOUSE, 9,  9,  0, 0, 0, 3, 0, 3'b000);
    cyc("unused",     NOP,   0,  0,  0, 0, 0, 0, 0, 3'b000);
    // multiply
    cyc("mul_r10",    MUL,   1,  2, 10, 0, 0, 0, 0, 3'b000);
    cyc("mul_busy1",  ALU,  10,  1, 11, 0, 0, 0, 0, 3'b111);
    cyc("mul_busy2",  ALU,  10,  1, 11, 0, 0, 0, 0, 3'b111);
    cyc("mul_busy3",  ALU,  10,  1, 11, 0, 0, 0, 0, 3'b111);
    cyc("mul_done",   ALU,  10,  1, 11, 0, 0, 0, 0, 3'b000);
    cyc("fwd_mul",    NOP,   0,  0,  0, 0, 1, 0, 0, 3'b000);
    // reset in the middle of a multiply
    cyc("mul_r12",    MUL,   1,  2, 12, 0, 0, 0, 0, 3'b000);
    cyc("mul2_busy",  NOP,   0,  0,  0, 0, 0, 0, 0, 3'b111);
    cyc("rst_mid",    NOP,   0,  0,  0, 0, 0, 0, 0, 3'b000);
    rst = 1'b1;
    cyc("post_rst",   ALUI, 12,  0, 13, 0, 0, 0, 0, 3'b000);
    rst = 1'b0;
    // flush
    cyc("lw_r14",     LW,    1,  0, 14, 0, 0, 0, 0, 3'b000);
    cyc("flush_lu",   ALU,  14, 14, 15, 1, 0, 0, 0, 3'b000);
    cyc("flush_dep",  ALUI, 14,  0, 16, 1, 0, 0, 0, 3'b000);
    cyc("flush_bub",  NOP,   0,  0,  0, 0, 0, 0, 0, 3'b000);
    // load with unused operands never stalls
    cyc("lw_r17",     LW,    1,  0, 17, 0, 0, 0, 0, 3'b000);
    cyc("nouse_ld",   NOUSW,17, 17, 18, 0, 0, 0, 0, 3'b000);
    cyc("nouse_sel",  NOP,   0,  0,  0, 0, 0, 0, 0, 3'b000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the in-order 5-stage CPU pipeline, successor to the combinational two-source bypass selector. It holds its own destination-tag pipeline for the instructions downstream of ID, resolves forwarding for both ALU sources and store data against up to DEPTH producer stages, and generates load-use and multi-cycle-multiply stalls. It sits beside the ID/EX pipeline register; its select outputs are registered and drive the EX operand and MEM store-data muxes directly.

## Interface
- REG_AW, 5: register-index width (32-entry GPR file).
- DEPTH, 3: forwarding sources tracked (1 = EX/MEM result, 2 = MEM/WB result, 3 = post-WB hold register); 2..7.
- LOAD_LAT, 1: load result valid at source index > LOAD_LAT.
- MUL_LAT, 4: EX-stage occupancy of a multiply, in cycles; 1..15.
- SELW, $clog2(DEPTH+1): select width (derived; not overridden).
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_AW  source and destination indices.
- id_use_rs, id_use_rt  in  1  operand read by ALU in EX.
- id_store  in  1  store; rt read as store data in MEM.
- id_wr  in  1  instruction writes id_rd.
- id_load, id_mul  in  1  instruction class.
- flush  in  1  kill the ID instruction (taken branch).
- fwd_a, fwd_b  out  SELW  EX operand selects (0 = register file, k = source k).
- fwd_c  out  SELW  MEM store-data select (same encoding).
- stall_id  out  1  hold PC and IF/ID.
- ex_hold  out  1  freeze ID/EX and EX (multiply in progress).
- mul_busy  out  1  multiply counter nonzero.

## Operation
- Tag pipeline tag[1..DEPTH], each {v, rd, load}; tag[1] = instruction in EX.
- Producer match on register r at tag[k]: v & rd == r & r != 0; youngest (lowest k) match wins.
- Encoding at issue: a producer at tag[k] in ID cycle supplies source k in the EX cycle.
- Load-use: operand used in EX matches load at tag[k] with k <= LOAD_LAT -> stall_id = 1.
- Store data (id_store, rt not used in EX): needed one stage later; match at tag[k] gives fwd_c = k+1 if k+1 <= DEPTH, else 0; load at tag[k] stalls only if k+1 <= LOAD_LAT.
- Multiply: when an id_mul instruction enters EX, counter loads MUL_LAT-1; while nonzero: mul_busy = ex_hold = stall_id = 1, tag[1] held, tag[2] receives a bubble, counter decrements.
- Shift per cycle, not ex_hold: tag[k] <= tag[k-1]; tag[1] <= {ID instr if id_valid & !flush & !stall_id & id_wr, else v=0}.
- fwd_a/b/c registered on the same edge as tag[1]; loaded with 0 when a bubble enters EX; held during ex_hold.
- flush with stall_id: flush wins; bubble enters EX, no stall next cycle from the killed instruction.
- Unused operand (id_use_* = 0) never stalls; select forced 0.

## Timing
- Reset: all tags invalid, counter 0, fwd_a = fwd_b = fwd_c = 0, stall_id = ex_hold = mul_busy = 0; reset mid-multiply clears counter immediately.
- stall_id combinational from tags, counter and ID inputs (same cycle); all other outputs registered, one-cycle latency.
- Load-use stall lasts LOAD_LAT-k+1 cycles for producer at tag[k]; default 1 cycle.
- Multiply occupies EX for exactly MUL_LAT cycles; MUL_LAT = 1 gives no stall.
- Back-to-back multiplies: second enters EX the cycle after counter reaches 0.

## Test plan
- add r3 in EX, ID add r4,r3,r1 -> next cycle fwd_a = 1, fwd_b = 0, no stall.
- lw r5 in EX, ID add r6,r5,r5 -> stall_id 1 for one cycle, then fwd_a = fwd_b = 2.
- lw r5 in EX, ID sw r5,0(r2) -> no stall, fwd_c = 2 in the store's EX cycle.
- Producers r7 at tag[1] and tag[2], ID reads r7 -> fwd = 1 (youngest); writes to r0 -> fwd = 0.
- mul in EX with MUL_LAT=4 -> ex_hold/stall_id/mul_busy high 3 cycles, dependent then gets fwd = 1.
- Assert rst during multiply cycle 2 -> all outputs 0 immediately; flush during load-use stall -> stall drops next cycle.
